// File: rtl/cmd_pkg.sv
// cmd_pkg: definitions shared by the command encoder and the command decoder.
// Holds the frame header, the opcode set, the frame lengths for both
// configurations (checksum via CMD_CHECKSUM_EN or plain) and FSM state types.
package cmd_pkg;

  localparam logic [7:0] CMD_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    OP_RESET    = 3'd0,
    OP_RES_DAC  = 3'd1,
    OP_INC_DAC1 = 3'd2,
    OP_INC_DAC2 = 3'd3,
    OP_READ     = 3'd4,
    OP_FPGA_SEL = 3'd5,
    OP_RESTEST  = 3'd6,
    OP_STARTUP  = 3'd7
  } cmd_op_t;

  // Bytes per frame: header, opcode, argument (+ checksum).
  localparam int FRAME_BYTES_PLAIN = 3;
  localparam int FRAME_BYTES_CSUM  = 4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {FR_IDLE, FR_SEND, FR_DONE} frame_state_t;

  // XOR of every byte that precedes the checksum byte.
  function automatic logic [7:0] cmd_checksum(input cmd_op_t op, input logic [7:0] arg);
    return CMD_HEADER ^ {5'b0, op} ^ arg;
  endfunction

endpackage

// File: rtl/cmd_uart_tx.sv
// cmd_uart_tx: 8N1 byte serializer. byte_ready is also high in the last cycle
// of a stop bit, so a byte offered then follows with no idle gap on the line.
module cmd_uart_tx
  import cmd_pkg::*;
#(
  parameter int BAUD_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       tx
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);

  tx_state_t       state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            bit_end;
  logic            take;

  assign bit_end    = (cnt == CNT_MAX);
  assign byte_ready = (state == TX_IDLE) || ((state == TX_STOP) && bit_end);
  assign take       = byte_valid && byte_ready;

  // Bit timing and START/DATA/STOP sequencing; tx is registered, reset forces it high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else if (take) begin
      state   <= TX_START;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= byte_data;
      tx      <= 1'b0;
    end else if (state == TX_IDLE) begin
      cnt <= '0;
      tx  <= 1'b1;
    end else if (!bit_end) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
      case (state)
        TX_START: begin
          state <= TX_DATA;
          tx    <= shreg[0];
          shreg <= {1'b0, shreg[7:1]};
        end
        TX_DATA: begin
          if (bit_idx == 3'd7) begin
            state   <= TX_STOP;
            bit_idx <= '0;
            tx      <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 3'd1;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
          end
        end
        default: begin
          state <= TX_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/cmd_encoder.sv
// cmd_encoder: accepts one command per handshake and sends the frame
// A5, {5'b0,op}, arg [, checksum] as 8N1 UART on tx.
// Macro CMD_CHECKSUM_EN: appends the XOR checksum byte (4-byte frames).
module cmd_encoder
  import cmd_pkg::*;
#(
  parameter int BAUD_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_arg,
  output logic       cmd_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

`ifdef CMD_CHECKSUM_EN
  localparam int FRAME_BYTES = FRAME_BYTES_CSUM;
`else
  localparam int FRAME_BYTES = FRAME_BYTES_PLAIN;
`endif
  localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 1);

  frame_state_t state;
  logic [1:0]   byte_idx;
  cmd_op_t      op_q;
  logic [7:0]   arg_q;
  logic         accept;
  logic         byte_valid;
  logic         byte_ready;
  logic [7:0]   byte_data;

  // cmd_ready is only high in IDLE/DONE, where the serializer is idle too.
  assign accept = cmd_valid && cmd_ready;

  // Next byte for the serializer: header on accept, otherwise the byte after byte_idx.
  always_comb begin
    byte_valid = accept;
    byte_data  = CMD_HEADER;
    if (state == FR_SEND) begin
      byte_valid = (byte_idx != LAST_IDX);
      case (byte_idx)
        2'd0:    byte_data = {5'b0, op_q};
        2'd1:    byte_data = arg_q;
`ifdef CMD_CHECKSUM_EN
        2'd2:    byte_data = cmd_checksum(op_q, arg_q);
`endif
        default: byte_data = CMD_HEADER;
      endcase
    end
  end

  // Frame FSM: command capture, byte sequencing, registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FR_IDLE;
      byte_idx   <= '0;
      op_q       <= OP_RESET;
      arg_q      <= '0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        FR_SEND: begin
          if (byte_ready) begin
            if (byte_idx == LAST_IDX) begin
              state      <= FR_DONE;
              byte_idx   <= '0;
              frame_done <= 1'b1;
              cmd_ready  <= 1'b1;
              busy       <= 1'b0;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        default: begin
          if (accept) begin
            op_q      <= cmd_op_t'(cmd_op);
            arg_q     <= cmd_arg;
            byte_idx  <= '0;
            state     <= FR_SEND;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end else begin
            state     <= FR_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
      endcase
    end
  end

  cmd_uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .tx         (tx)
  );

endmodule

// File: tb/tb_cmd_encoder.sv
// tb_cmd_encoder: directed frames with hand-computed bytes, BAUD_DIV=4.
module tb_cmd_encoder;

  localparam int BD = 4;
`ifdef CMD_CHECKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif
  localparam int LEN = 10 * NB * BD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_arg = 8'd0;
  logic       cmd_ready, tx, busy, frame_done;

  int checks = 0;
  int errors = 0;

  cmd_encoder #(.BAUD_DIV(BD)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .cmd_ready  (cmd_ready),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a command once ready; returns at the negedge of the first start-bit cycle.
  task automatic issue(input logic [2:0] op, input logic [7:0] arg, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Sample tx every cycle of the frame against the ideal waveform, decode bytes
  // mid-bit, then check the DONE cycle (LEN+1 cycles after accept).
  task automatic capture(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] e [4];
    logic [7:0] g [4];
    logic [7:0] cur;
    int bad, early, nbusy, pos, by, bn;
    logic eb;
    e = '{b0, b1, b2, b3};
    g = '{8'd0, 8'd0, 8'd0, 8'd0};
    bad = 0; early = 0; nbusy = 0;
    for (int c = 1; c <= LEN; c++) begin
      pos = c - 1;
      by  = pos / (10 * BD);
      bn  = (pos % (10 * BD)) / BD;
      cur = e[by];
      if (bn == 0)      eb = 1'b0;
      else if (bn == 9) eb = 1'b1;
      else              eb = cur[bn-1];
      if (tx !== eb) bad++;
      if ((pos % BD) == BD / 2 && bn >= 1 && bn <= 8) g[by][bn-1] = tx;
      if (frame_done !== 1'b0) early++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0) nbusy++;
      @(negedge clk);
    end
    for (int i = 0; i < NB; i++)
      check($sformatf("%s_byte%0d", tag, i), {24'd0, g[i]}, {24'd0, e[i]});
    check({tag, "_wave"}, bad, 0);
    check({tag, "_early_done"}, early, 0);
    check({tag, "_busy"}, nbusy, 0);
    check({tag, "_done"}, {31'd0, frame_done}, 32'd1);
    check({tag, "_done_ready"}, {29'd0, cmd_ready, busy, tx}, 32'b101);
  endtask

  initial begin
    // Reset held
    repeat (3) @(negedge clk);
    check("rst_hold", {28'd0, tx, cmd_ready, busy, frame_done}, 32'b1100);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_release", {28'd0, tx, cmd_ready, busy, frame_done}, 32'b1100);

    // Read command: op 4, arg 0x12 -> A5 04 12 [B3]
    issue(3'd4, 8'h12, 1'b0);
    capture("read", 8'hA5, 8'h04, 8'h12, 8'hB3);
    @(negedge clk);
    check("read_idle", {30'd0, tx, busy}, 32'b10);

    // Back-to-back with cmd_valid held: op 5 arg 03, then op 2 arg 03
    issue(3'd5, 8'h03, 1'b1);
    fork
      capture("b2b1", 8'hA5, 8'h05, 8'h03, 8'hA3);
      begin
        repeat (60) @(negedge clk);
        cmd_op = 3'd2;
      end
    join
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b_start", {31'd0, tx}, 32'd0);
    capture("b2b2", 8'hA5, 8'h02, 8'h03, 8'hA4);

    // Busy: extra op-7 pulse ignored; arg changes mid-frame do not leak in
    issue(3'd3, 8'hC6, 1'b0);
    fork
      capture("hold", 8'hA5, 8'h03, 8'hC6, 8'h60);
      begin
        repeat (19) @(negedge clk);
        cmd_op    = 3'd7;
        cmd_arg   = 8'hFF;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_arg   = 8'h39;
      end
    join
    repeat (3) @(negedge clk);
    check("hold_no_queue", {30'd0, tx, busy}, 32'b10);

    // Reset during data bit 1 of byte 1 (opcode 4, that bit is 0)
    issue(3'd4, 8'h12, 1'b0);
    repeat (49) @(negedge clk);
    check("pre_rst_tx", {31'd0, tx}, 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst", {29'd0, tx, cmd_ready, busy}, 32'b110);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst", {28'd0, tx, cmd_ready, busy, frame_done}, 32'b1100);
    issue(3'd1, 8'h5A, 1'b0);
    capture("after_rst", 8'hA5, 8'h01, 8'h5A, 8'hFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmd_encoder.md
# cmd_encoder

Host-side command encoder: the transmitting end of the control-unit command link. Accepts one command per handshake (opcode plus 8-bit argument), builds a fixed byte frame and serializes it as 8N1 UART on `tx`. The receiving FPGA's UART receiver and command decoder consume these frames. Used in test harnesses and in a master FPGA driving slave chronometer boards.

## Interface
Parameters:
- `BAUD_DIV`, 16, clk cycles per UART bit; minimum 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_op`  in  3  opcode: 0 reset, 1 res_dac, 2 inc_dac1, 3 inc_dac2, 4 read, 5 fpga_sel, 6 restest, 7 startup.
- `cmd_arg`  in  8  argument: address for read, board id for fpga_sel, don't-care otherwise. It is still transmitted.
- `cmd_ready`  out  1  encoder can accept a command.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse at frame completion.

## Operation
- Frame byte order: header `0xA5`, opcode byte `{5'b0, cmd_op}`, `cmd_arg`, then optional checksum (see Configuration).
- Each byte is 8N1: start bit 0, 8 data bits LSB first, stop bit 1.
- Handshake:
  - A command is accepted in a cycle where `cmd_valid && cmd_ready`.
  - `cmd_op` and `cmd_arg` are registered in that cycle. Later changes do not affect the frame.
  - `cmd_valid` while `cmd_ready`=0 is ignored and not queued.
- FSM states:
  - IDLE: `cmd_ready`=1, `tx`=1. Goes to START on accept.
  - START: `tx`=0 for one bit time, then DATA.
  - DATA: 8 bit times, LSB first, then STOP.
  - STOP: `tx`=1 for one bit time. Goes to START with the next byte, or to DONE after the last byte.
  - DONE: one cycle. `frame_done`=1, `cmd_ready`=1. Goes to IDLE, or straight to START if a command is accepted in this cycle.
- Counters:
  - Bit-time counter, 0..`BAUD_DIV`-1, cleared on accept and on every bit boundary.
  - Bit index 0..7.
  - Byte index 0..N-1, where N = 3, or 4 with checksum.
- `busy` = 1 in every state except IDLE and DONE.
- Reset:
  - Values: `tx`=1, `cmd_ready`=1, `busy`=0, `frame_done`=0, FSM IDLE, all counters 0.
  - Reset mid-frame aborts the frame immediately, with `tx` forced high asynchronously. The partial frame is not resumed.

## Timing
- The start bit of byte 0 appears on `tx` the cycle after acceptance (registered output).
- Each bit lasts exactly `BAUD_DIV` cycles. There is no idle gap between the bytes of one frame.
- Frame length is 10·N·`BAUD_DIV` cycles: 30·`BAUD_DIV`, or 40·`BAUD_DIV` with checksum.
- `frame_done` pulses in the cycle after the last stop bit ends. `cmd_ready` rises in the same cycle.
- Back-to-back: a command accepted in the DONE cycle starts its start bit on the next cycle. The minimum line-idle gap between frames is 1 cycle.
- Throughput: one command per 10·N·`BAUD_DIV`+1 cycles.

## Configuration
- `CMD_CHECKSUM_EN` defined:
  - Frame is 4 bytes. Byte 3 = header ^ opcode byte ^ arg.
  - Byte index counts 0..3.
- Undefined:
  - Frame is 3 bytes. No checksum logic or state is present.
  - Frame length and DONE timing follow N=3.

## Structure
- Shared package `cmd_pkg` holds:
  - `CMD_HEADER` = 8'hA5.
  - The opcode enum `cmd_op_t`, values 0..7 as listed above.
  - Frame length constants for both configurations.
- The command decoder uses the same package, so encoder and decoder share one opcode definition.
- Sub-module `cmd_uart_tx`: a byte serializer with `BAUD_DIV` and a byte-level valid/ready handshake, holding the START/DATA/STOP logic.
- `cmd_encoder` keeps the frame FSM (byte sequencing, checksum, command handshake).

## Test plan
- Reset: hold `rst`=0, then release → `tx`=1, `cmd_ready`=1, `busy`=0, `frame_done`=0.
- Read command:
  - Stimulus: `BAUD_DIV`=4, op=4, arg=0x12, `CMD_CHECKSUM_EN` defined.
  - Required: decoded bytes A5, 04, 12, B3. Each bit exactly 4 cycles. `frame_done` 161 cycles after accept.
- Same command without the macro → bytes A5, 04, 12. `frame_done` 121 cycles after accept.
- Back-to-back:
  - Stimulus: `cmd_valid` held high with op=5 arg=0x03, then op=2.
  - Required: second start bit begins the cycle after the first `frame_done`. Second command's bytes are correct.
- Busy and mid-change:
  - Stimulus: pulse `cmd_valid` with op=7 during a frame; change `cmd_arg` mid-frame.
  - Required: the extra command is ignored. The current frame carries the originally captured argument.
- Reset mid-frame: assert `rst` during the DATA bits of byte 1 → `tx`=1 the same cycle, FSM IDLE. The next command sends a complete, correct frame.
